// File: rtl/mx_block_quantizer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mx_block_quantizer_if : element-in / MX-element-out stream bundle  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface mx_block_quantizer_if #(
   parameter int EXP_WIDTH = 8,
   parameter int MAN_WIDTH = 7,
   parameter int OUT_WIDTH = 8
);
   logic                 i_valid;
   logic                 o_ready;
   logic                 i_sign;
   logic [EXP_WIDTH-1:0] i_exp;
   logic [MAN_WIDTH-1:0] i_man;
   logic                 o_valid;
   logic                 i_ready;
   logic [EXP_WIDTH-1:0] o_scale;
   logic                 o_sign;
   logic [OUT_WIDTH-1:0] o_man;
   logic                 o_last;

   modport master (
      output i_valid, i_sign, i_exp, i_man, i_ready,
      input  o_ready, o_valid, o_scale, o_sign, o_man, o_last
   );

   modport slave (
      input  i_valid, i_sign, i_exp, i_man, i_ready,
      output o_ready, o_valid, o_scale, o_sign, o_man, o_last
   );
endinterface
`default_nettype wire

// File: rtl/mx_block_quantizer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mx_block_quantizer : buffers one block, finds the shared exponent, |
// | then drains mantissas aligned to it.                 Rev 1.0       |
// +--------------------------------------------------------------------+
module mx_block_quantizer #(
   parameter int EXP_WIDTH = 8,
   parameter int MAN_WIDTH = 7,
   parameter int OUT_WIDTH = 8,
   parameter int LENGTH    = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   mx_block_quantizer_if.slave   bus
);
   localparam int IDX_W = $clog2(LENGTH);
   localparam logic [0:0] FILL  = 1'b0;
   localparam logic [0:0] DRAIN = 1'b1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LENGTH - 1);

   logic [0:0]           state;
   logic [IDX_W-1:0]     idx;
   logic [EXP_WIDTH-1:0] e_max;

   logic                 sign_buf [LENGTH];
   logic [EXP_WIDTH-1:0] exp_buf  [LENGTH];
   logic [MAN_WIDTH-1:0] man_buf  [LENGTH];

   logic in_hs;
   logic out_hs;
   logic at_last;
   logic draining;

   assign draining = (state == DRAIN) & ~i_rst;
   assign in_hs    = bus.i_valid & bus.o_ready;
   assign out_hs   = bus.o_valid & bus.i_ready;
   assign at_last  = (idx == LAST_IDX);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= FILL;
         idx   <= '0;
         e_max <= '0;
      end else begin
         case (state)
            FILL: begin
               if (in_hs) begin
                  idx <= idx + 1'b1;
                  if (bus.i_exp > e_max) e_max <= bus.i_exp;
                  if (at_last) state <= DRAIN;
               end
            end
            default: begin
               if (out_hs) begin
                  idx <= idx + 1'b1;
                  if (at_last) begin
                     e_max <= '0;
                     state <= FILL;
                  end
               end
            end
         endcase
      end
   end

   // Storage needs no reset: it is only read after a full block is written.
   always_ff @(posedge i_clk) begin
      if (in_hs) begin
         sign_buf[idx] <= bus.i_sign;
         exp_buf[idx]  <= bus.i_exp;
         man_buf[idx]  <= bus.i_man;
      end
   end

   logic [EXP_WIDTH-1:0] cur_exp;
   logic [MAN_WIDTH:0]   sig;
   logic [OUT_WIDTH-1:0] top;
   logic [EXP_WIDTH-1:0] shift;
   logic [OUT_WIDTH-1:0] aligned;

   // Explicit range test keeps large shifts from aliasing to small ones.
   always_comb begin
      cur_exp = exp_buf[idx];
      sig     = {(cur_exp != '0), man_buf[idx]};
      top     = sig[MAN_WIDTH -: OUT_WIDTH];
      shift   = e_max - cur_exp;
      aligned = '0;
      if ((cur_exp != '0) && (32'(shift) < 32'(OUT_WIDTH)))
         aligned = top >> shift;
   end

   assign bus.o_ready = (state == FILL) & ~i_rst;
   assign bus.o_valid = draining;
   assign bus.o_scale = draining ? e_max : '0;
   assign bus.o_sign  = draining & sign_buf[idx];
   assign bus.o_man   = draining ? aligned : '0;
   assign bus.o_last  = draining & at_last;

endmodule
`default_nettype wire
